// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants and control-FSM state type
package cpu_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] OP_BRZ  = 4'hC;
    localparam logic [3:0] OP_BRNZ = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - fetch-side inputs and PC load / issue outputs of pc_ctrl
interface pc_ctrl_if #(
    parameter int BUS_WIDTH = 16
);
    logic [BUS_WIDTH-1:0] instr;
    logic                 instr_valid;
    logic                 zero;
    logic                 PL;
    logic                 JB;
    logic [5:0]           offset;
    logic                 flush;
    logic                 issue;
    logic [BUS_WIDTH-1:0] ir;
    logic                 halted;

    modport master (
        output instr, instr_valid, zero,
        input  PL, JB, offset, flush, issue, ir, halted
    );

    modport slave (
        input  instr, instr_valid, zero,
        output PL, JB, offset, flush, issue, ir, halted
    );
endinterface

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode classification, shared with execute
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       zero_i,
    output logic       is_ctrl_o,
    output logic       is_jump_o,
    output logic       is_branch_o,
    output logic       branch_taken_o,
    output logic       is_halt_o
);

    assign is_jump_o      = (op_i == OP_JMP);
    assign is_halt_o      = (op_i == OP_HALT);
    assign is_branch_o    = (op_i == OP_BRZ) || (op_i == OP_BRNZ);
    assign branch_taken_o = ((op_i == OP_BRZ) && zero_i) || ((op_i == OP_BRNZ) && !zero_i);
    assign is_ctrl_o      = is_jump_o || is_branch_o || is_halt_o;

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - decodes fetched instructions, drives PC load and squashes wrong-path fetches
module pc_ctrl
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH    = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    pc_ctrl_if.slave      bus
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pl_q, pl_d;
    logic                 jb_q, jb_d;
    logic [5:0]           offset_q, offset_d;
    logic                 flush_q, flush_d;
    logic                 issue_q, issue_d;
    logic [BUS_WIDTH-1:0] ir_q, ir_d;
    logic                 halted_q, halted_d;

    logic is_ctrl, is_jump, is_branch, branch_taken, is_halt;

    instr_decode u_decode (
        .op_i           (bus.instr[OPC_MSB:OPC_LSB]),
        .zero_i         (bus.zero),
        .is_ctrl_o      (is_ctrl),
        .is_jump_o      (is_jump),
        .is_branch_o    (is_branch),
        .branch_taken_o (branch_taken),
        .is_halt_o      (is_halt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            pl_q     <= 1'b0;
            jb_q     <= 1'b0;
            offset_q <= '0;
            flush_q  <= 1'b0;
            issue_q  <= 1'b0;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pl_q     <= pl_d;
            jb_q     <= jb_d;
            offset_q <= offset_d;
            flush_q  <= flush_d;
            issue_q  <= issue_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pl_d     = 1'b0;
        jb_d     = jb_q;
        offset_d = offset_q;
        flush_d  = flush_q;
        issue_d  = 1'b0;
        ir_d     = ir_q;
        halted_d = halted_q;

        unique case (state_q)
            ST_RUN: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    issue_d = !is_ctrl;
                    if (is_halt) begin
                        halted_d = 1'b1;
                        pl_d     = 1'b1;
                        jb_d     = 1'b0;
                        offset_d = '0;
                        state_d  = ST_HALT;
                    end else if (is_jump || (is_branch && branch_taken)) begin
                        pl_d     = 1'b1;
                        jb_d     = is_jump;
                        offset_d = bus.instr[5:0];
                        state_d  = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                jb_d    = 1'b0;
                flush_d = 1'b1;
                cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Fetches still in flight from the old PC are dropped unseen.
                if (cnt_q == '0) begin
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALT: begin
                // PC keeps branching to itself with a zero offset.
                pl_d     = 1'b1;
                jb_d     = 1'b0;
                offset_d = '0;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.PL     = pl_q;
    assign bus.JB     = jb_q;
    assign bus.offset = offset_q;
    assign bus.flush  = flush_q;
    assign bus.issue  = issue_q;
    assign bus.ir     = ir_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - two pc_ctrl instances (flush 1 and 3) against a timestamp model
module tb_pc_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        zero;
    logic        cmp_en;
    int          n_cmp;
    int          n_bad;

    pc_ctrl_if #(.BUS_WIDTH(16)) if1 ();
    pc_ctrl_if #(.BUS_WIDTH(16)) if3 ();

    assign if1.instr = instr;
    assign if1.instr_valid = instr_valid;
    assign if1.zero = zero;
    assign if3.instr = instr;
    assign if3.instr_valid = instr_valid;
    assign if3.zero = zero;

    pc_ctrl #(.BUS_WIDTH(16), .FLUSH_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    pc_ctrl #(.BUS_WIDTH(16), .FLUSH_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a taken control op at edge n makes PL visible after edge n,
    // flush visible after edges n+1..n+F, and inputs ignored through edge n+1+F.
    int          fcyc [2];
    int          edge_n;
    int          redir [2];
    int          ignore_until [2];
    logic        m_pl [2];
    logic        m_jb [2];
    logic [5:0]  m_off [2];
    logic        m_flush [2];
    logic        m_issue [2];
    logic [15:0] m_ir [2];
    logic        m_halted [2];

    initial begin
        fcyc[0] = 1;
        fcyc[1] = 3;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_n = 0;
            for (int i = 0; i < 2; i++) begin
                redir[i] = -100; ignore_until[i] = -1;
                m_pl[i] = 0; m_jb[i] = 0; m_off[i] = 0; m_flush[i] = 0;
                m_issue[i] = 0; m_ir[i] = 0; m_halted[i] = 0;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < 2; i++) begin
                m_flush[i] = (edge_n >= redir[i] + 1) && (edge_n <= redir[i] + fcyc[i]);
                m_issue[i] = 0;
                if (m_halted[i]) begin
                    m_pl[i] = 1; m_jb[i] = 0; m_off[i] = 0;
                end else if (edge_n <= ignore_until[i]) begin
                    m_pl[i] = 0; m_jb[i] = 0;
                end else begin
                    m_pl[i] = 0;
                    if (instr_valid) begin
                        m_ir[i] = instr;
                        if (instr[15:12] == 4'hF) begin
                            m_halted[i] = 1; m_pl[i] = 1; m_jb[i] = 0; m_off[i] = 0;
                        end else if (instr[15:12] == 4'hE ||
                                     (instr[15:12] == 4'hC && zero) ||
                                     (instr[15:12] == 4'hD && !zero)) begin
                            m_pl[i] = 1;
                            m_jb[i] = (instr[15:12] == 4'hE);
                            m_off[i] = instr[5:0];
                            redir[i] = edge_n;
                            ignore_until[i] = edge_n + 1 + fcyc[i];
                        end else if (instr[15:12] != 4'hC && instr[15:12] != 4'hD) begin
                            m_issue[i] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("u1.PL", 32'(if1.PL), 32'(m_pl[0]));
            chk("u1.JB", 32'(if1.JB), 32'(m_jb[0]));
            chk("u1.offset", 32'(if1.offset), 32'(m_off[0]));
            chk("u1.flush", 32'(if1.flush), 32'(m_flush[0]));
            chk("u1.issue", 32'(if1.issue), 32'(m_issue[0]));
            chk("u1.ir", 32'(if1.ir), 32'(m_ir[0]));
            chk("u1.halted", 32'(if1.halted), 32'(m_halted[0]));
            chk("u3.PL", 32'(if3.PL), 32'(m_pl[1]));
            chk("u3.JB", 32'(if3.JB), 32'(m_jb[1]));
            chk("u3.offset", 32'(if3.offset), 32'(m_off[1]));
            chk("u3.flush", 32'(if3.flush), 32'(m_flush[1]));
            chk("u3.issue", 32'(if3.issue), 32'(m_issue[1]));
            chk("u3.ir", 32'(if3.ir), 32'(m_ir[1]));
            chk("u3.halted", 32'(if3.halted), 32'(m_halted[1]));
        end
    end

    task automatic cyc(input logic v, input logic [15:0] i, input logic z);
        instr = i;
        instr_valid = v;
        zero = z;
        @(posedge clk);
        #1;
    endtask

    int pl1, pl3, fl1, fl3;

    initial begin
        n_cmp = 0; n_bad = 0; cmp_en = 0;
        reset = 0; instr = '0; instr_valid = 0; zero = 0;
        @(posedge clk); #1;
        cmp_en = 1;
        cyc(1, 16'h1234, 0);
        chk("rst_pl", 32'(if1.PL | if3.PL), 0);
        chk("rst_issue", 32'(if1.issue | if3.issue), 0);
        chk("rst_ir", 32'(if1.ir | if3.ir), 0);
        chk("rst_flush_halted", 32'({if1.flush, if3.flush, if1.halted, if3.halted}), 0);
        reset = 1;

        for (int k = 0; k < 3; k++) begin
            cyc(1, 16'h1234, 0);
            chk("nc_issue", 32'(if1.issue), 1);
            chk("nc_ir", 32'(if1.ir), 32'h1234);
            chk("nc_pl", 32'(if1.PL), 0);
        end

        cyc(1, 16'hC002, 1);
        chk("brz_pl", 32'({if1.PL, if3.PL}), 32'h3);
        chk("brz_jb", 32'(if1.JB), 0);
        chk("brz_off", 32'(if1.offset), 32'h02);
        chk("brz_issue", 32'(if1.issue), 0);
        cyc(0, 16'h0000, 0);
        chk("brz_pl_drop", 32'(if1.PL), 0);
        chk("brz_flush", 32'({if1.flush, if3.flush}), 32'h3);
        chk("brz_issue2", 32'(if1.issue), 0);
        cyc(0, 16'h0000, 0);
        chk("brz_flush_u1_end", 32'(if1.flush), 0);
        chk("brz_flush_u3_on", 32'(if3.flush), 1);
        for (int k = 0; k < 4; k++) cyc(0, 16'h0000, 0);

        cyc(1, 16'hD03E, 1);
        chk("brnz_nt_pl", 32'({if1.PL, if3.PL}), 0);
        chk("brnz_nt_issue", 32'(if1.issue), 0);
        chk("brnz_nt_ir", 32'(if1.ir), 32'hD03E);
        cyc(1, 16'h0001, 0);
        chk("after_nt_issue", 32'(if3.issue), 1);
        chk("after_nt_ir", 32'(if3.ir), 32'h0001);
        chk("after_nt_flush", 32'({if1.flush, if3.flush}), 0);

        cyc(1, 16'hE000, 0);
        chk("jmp_pl", 32'({if1.PL, if3.PL}), 32'h3);
        chk("jmp_jb", 32'({if1.JB, if3.JB}), 32'h3);
        pl1 = 0; pl3 = 0; fl1 = 0; fl3 = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) cyc(1, 16'hE000, 0); else cyc(0, 16'h0000, 0);
            pl1 += int'(if1.PL); pl3 += int'(if3.PL);
            fl1 += int'(if1.flush); fl3 += int'(if3.flush);
        end
        chk("jmp2_pl_u1", 32'(pl1), 0);
        chk("jmp2_pl_u3", 32'(pl3), 0);
        chk("jmp_flush_w1", 32'(fl1), 1);
        chk("jmp_flush_w3", 32'(fl3), 3);

        cyc(1, 16'hE000, 0);
        cyc(0, 16'h0000, 0);
        chk("rf_flush_on", 32'(if3.flush), 1);
        #2 reset = 0;
        #1;
        chk("rf_flush_async", 32'(if3.flush), 0);
        chk("rf_pl_async", 32'(if1.PL | if3.PL), 0);
        @(posedge clk); #1;
        reset = 1;
        cyc(1, 16'h0042, 0);
        chk("rf_issue", 32'(if3.issue), 1);
        chk("rf_ir", 32'(if3.ir), 32'h0042);
        chk("rf_no_flush", 32'(if3.flush), 0);
        for (int k = 0; k < 4; k++) cyc(0, 16'h0000, 0);

        cyc(1, 16'hD03E, 0);
        chk("brnz_t_off", 32'(if1.offset), 32'h3E);
        for (int k = 0; k < 5; k++) cyc(0, 16'h0000, 0);
        cyc(1, 16'hF000, 0);
        chk("halt_halted", 32'({if1.halted, if3.halted}), 32'h3);
        chk("halt_pl", 32'(if1.PL), 1);
        chk("halt_jb", 32'(if1.JB), 0);
        chk("halt_off", 32'(if1.offset), 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) cyc(1, 16'hC002, 1); else cyc(1, 16'h1234, 0);
            chk("halt_hold_pl", 32'({if1.PL, if3.PL}), 32'h3);
            chk("halt_hold_off", 32'(if3.offset), 0);
            chk("halt_hold_issue", 32'(if3.issue), 0);
        end
        #2 reset = 0;
        #1;
        chk("halt_rst_halted", 32'(if1.halted | if3.halted), 0);
        chk("halt_rst_pl", 32'(if1.PL | if3.PL), 0);
        @(posedge clk); #1;
        reset = 1;
        cyc(0, 16'h0000, 0);
        chk("post_halt_run", 32'({if1.halted, if1.PL}), 0);

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
